// File: rtl/mips_pkg.sv
// Shared definitions for the 8-bit pipeline: datapath widths and the
// memory-stage state encoding.
package mips_pkg;

    localparam int DATA_W              = 8;
    localparam int ADDR_W              = 8;
    localparam int MEM_DEPTH           = 1 << ADDR_W;
    localparam int CNT_W               = 4;
    localparam int DEFAULT_WAIT_STATES = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mem_state_t;

endpackage

// File: rtl/mem_stage_if.sv
// EX/MEM-to-memory-stage bundle: request side from the pipeline register,
// load result and stall back towards the pipeline.
interface mem_stage_if;
    import mips_pkg::*;

    logic [ADDR_W-1:0] EX_MEM_alu_out;
    logic [DATA_W-1:0] EX_MEM_write_data;
    logic              EX_MEM_mem_read;
    logic              EX_MEM_mem_write;
    logic [DATA_W-1:0] mem_out_data;
    logic              mem_stall;

    modport master (
        output EX_MEM_alu_out, EX_MEM_write_data, EX_MEM_mem_read, EX_MEM_mem_write,
        input  mem_out_data, mem_stall
    );

    modport slave (
        input  EX_MEM_alu_out, EX_MEM_write_data, EX_MEM_mem_read, EX_MEM_mem_write,
        output mem_out_data, mem_stall
    );
endinterface

// File: rtl/data_mem_array.sv
// 256x8 data memory: synchronous write, asynchronous read, contents are
// deliberately not reset so they survive a pipeline reset.
module data_mem_array
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: accepts one load/store at a time, holds the pipeline
// for WAIT_STATES+2 cycles, then releases it for one DONE cycle.
module mem_stage
    import mips_pkg::*;
#(
    parameter int WAIT_STATES = DEFAULT_WAIT_STATES
) (
    input  logic     clk,
    input  logic     reset,
    mem_stage_if.slave bus
);

    mem_state_t        state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] data_reg;
    logic              is_write_reg;
    logic [DATA_W-1:0] out_reg;
    logic [DATA_W-1:0] rdata;
    logic              req;
    logic              access;

    assign req    = bus.EX_MEM_mem_read | bus.EX_MEM_mem_write;
    assign access = (state_reg == BUSY) && (cnt_reg == '0);

    data_mem_array u_mem (
        .clk   (clk),
        .we    (access && is_write_reg),
        .addr  (addr_reg),
        .wdata (data_reg),
        .rdata (rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            addr_reg     <= '0;
            data_reg     <= '0;
            is_write_reg <= 1'b0;
            out_reg      <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req) begin
                        addr_reg     <= bus.EX_MEM_alu_out;
                        data_reg     <= bus.EX_MEM_write_data;
                        // Read+write together is a store.
                        is_write_reg <= bus.EX_MEM_mem_write;
                        cnt_reg      <= CNT_W'(WAIT_STATES);
                        state_reg    <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt_reg != '0) begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end else begin
                        if (!is_write_reg) begin
                            out_reg <= rdata;
                        end
                        state_reg <= DONE;
                    end
                end
                DONE:    state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Gated by reset so the stall drops at once even while req is still held.
    assign bus.mem_stall    = reset & (((state_reg == IDLE) & req) | (state_reg == BUSY));
    assign bus.mem_out_data = out_reg;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: one instance with 2 wait states, one with 0.
module tb_mem_stage;
    import mips_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   n;

    always #5 clk = ~clk;

    mem_stage_if if_a();
    mem_stage_if if_b();

    mem_stage #(.WAIT_STATES(2)) dut_a (.clk(clk), .reset(reset), .bus(if_a.slave));
    mem_stage #(.WAIT_STATES(0)) dut_b (.clk(clk), .reset(reset), .bus(if_b.slave));

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
        $display("check %-14s observed %02h expected %02h", tag, obs, exp);
    endtask

    task automatic set_in(input int which, input logic rd, input logic wr,
                          input logic [7:0] a, input logic [7:0] d);
        if (which == 0) begin
            if_a.EX_MEM_mem_read = rd; if_a.EX_MEM_mem_write = wr;
            if_a.EX_MEM_alu_out  = a;  if_a.EX_MEM_write_data = d;
        end else begin
            if_b.EX_MEM_mem_read = rd; if_b.EX_MEM_mem_write = wr;
            if_b.EX_MEM_alu_out  = a;  if_b.EX_MEM_write_data = d;
        end
    endtask

    function automatic logic stall_of(input int which);
        return (which == 0) ? if_a.mem_stall : if_b.mem_stall;
    endfunction

    function automatic logic [7:0] out_of(input int which);
        return (which == 0) ? if_a.mem_out_data : if_b.mem_out_data;
    endfunction

    // Called just after a rising edge with the FSM in IDLE; returns in DONE.
    task automatic op(input int which, input logic rd, input logic wr,
                      input logic [7:0] a, input logic [7:0] d,
                      input int exp_n, input string tag);
        int cnt;
        set_in(which, rd, wr, a, d);
        #1;
        cnt = 0;
        while (stall_of(which) === 1'b1 && cnt < 40) begin
            cnt++;
            @(posedge clk); #1;
        end
        chk(tag, 8'(cnt), 8'(exp_n));
    endtask

    task automatic idle_cycle(input int which);
        set_in(which, 1'b0, 1'b0, 8'h00, 8'h00);
        @(posedge clk); #1;
    endtask

    initial begin
        // Reset with random inputs applied
        set_in(0, 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom));
        set_in(1, 1'b1, 1'($urandom), 8'($urandom), 8'($urandom));
        repeat (3) @(posedge clk);
        #1;
        chk("rst out_a",   if_a.mem_out_data, 8'h00);
        chk("rst stall_a", 8'(if_a.mem_stall), 8'h00);
        chk("rst out_b",   if_b.mem_out_data, 8'h00);
        chk("rst stall_b", 8'(if_b.mem_stall), 8'h00);
        chk("rst state_a", 8'(dut_a.state_reg), 8'(IDLE));
        set_in(0, 1'b0, 1'b0, 8'h00, 8'h00);
        set_in(1, 1'b0, 1'b0, 8'h00, 8'h00);
        reset = 1'b1;
        @(posedge clk); #1;

        // Store then load, 2 wait states
        op(0, 1'b0, 1'b1, 8'h3C, 8'hA5, 4, "st3C stalls");
        idle_cycle(0);
        op(0, 1'b1, 1'b0, 8'h3C, 8'h00, 4, "ld3C stalls");
        chk("ld3C data", out_of(0), 8'hA5);
        idle_cycle(0);

        // Boundary addresses, 0 wait states
        op(1, 1'b0, 1'b1, 8'h00, 8'h11, 2, "st00 stalls");
        idle_cycle(1);
        op(1, 1'b0, 1'b1, 8'hFF, 8'hEE, 2, "stFF stalls");
        idle_cycle(1);
        op(1, 1'b1, 1'b0, 8'h00, 8'h00, 2, "ld00 stalls");
        chk("ld00 data", out_of(1), 8'h11);
        idle_cycle(1);
        op(1, 1'b1, 1'b0, 8'hFF, 8'h00, 2, "ldFF stalls");
        chk("ldFF data", out_of(1), 8'hEE);
        idle_cycle(1);

        // Address churn during BUSY is ignored
        op(0, 1'b0, 1'b1, 8'h10, 8'h5A, 4, "st10 stalls");
        idle_cycle(0);
        op(0, 1'b0, 1'b1, 8'h20, 8'hC3, 4, "st20 stalls");
        idle_cycle(0);
        set_in(0, 1'b1, 1'b0, 8'h10, 8'h00);
        #1;
        chk("churn stall0", 8'(stall_of(0)), 8'h01);
        @(posedge clk); #1;
        set_in(0, 1'b1, 1'b0, 8'h20, 8'h00);
        n = 1;
        while (stall_of(0) === 1'b1 && n < 40) begin
            n++;
            @(posedge clk); #1;
        end
        chk("churn stalls", 8'(n), 8'h04);
        chk("churn data", out_of(0), 8'h5A);
        idle_cycle(0);

        // Read and write together act as a store
        op(0, 1'b1, 1'b1, 8'h30, 8'h99, 4, "rdwr stalls");
        chk("rdwr out hold", out_of(0), 8'h5A);
        idle_cycle(0);
        op(0, 1'b1, 1'b0, 8'h30, 8'h00, 4, "ld30 stalls");
        chk("ld30 data", out_of(0), 8'h99);
        idle_cycle(0);

        // Back-to-back: next instruction appears during DONE
        op(0, 1'b0, 1'b1, 8'h50, 8'h42, 4, "b2b st stalls");
        set_in(0, 1'b1, 1'b0, 8'h50, 8'h00);
        #1;
        chk("b2b done gap", 8'(stall_of(0)), 8'h00);
        @(posedge clk); #1;
        op(0, 1'b1, 1'b0, 8'h50, 8'h00, 4, "b2b ld stalls");
        chk("b2b ld data", out_of(0), 8'h42);
        idle_cycle(0);

        // Reset in the middle of a store drops it
        op(0, 1'b0, 1'b1, 8'h40, 8'h01, 4, "st40 stalls");
        idle_cycle(0);
        set_in(0, 1'b0, 1'b1, 8'h40, 8'h77);
        @(posedge clk); #1;
        chk("mid busy stall", 8'(stall_of(0)), 8'h01);
        #2 reset = 1'b0;
        #1;
        chk("mid rst stall", 8'(stall_of(0)), 8'h00);
        chk("mid rst state", 8'(dut_a.state_reg), 8'(IDLE));
        @(posedge clk); #1;
        set_in(0, 1'b0, 1'b0, 8'h00, 8'h00);
        #2 reset = 1'b1;
        @(posedge clk); #1;
        op(0, 1'b1, 1'b0, 8'h40, 8'h00, 4, "ld40 stalls");
        chk("ld40 data", out_of(0), 8'h01);
        idle_cycle(0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
